// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants K[0..63], initial hash value (IV),
// the round mixing functions and the compression FSM state type.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // IV_W[0] is H0.
    localparam logic [31:0] IV_W [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Sigma0 = ROTR2 ^ ROTR13 ^ ROTR22
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    // Sigma1 = ROTR6 ^ ROTR11 ^ ROTR25
    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant K[t].
//   i_addr : round index t (0..63)
//   o_data : K[t]
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  i_addr,
    output logic [31:0] o_data
);

    assign o_data = K[i_addr];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine. Consumes one W[t] word per accepted cycle, runs 64
// rounds on a..h, then folds a..h into the running hash H0..H7, which persists
// across chunks of the same message.
//   clk, rst_n   : clock, asynchronous active-low reset
//   msg_init     : load H with the IV (IDLE only)
//   chunk_start  : copy H into a..h and begin 64 rounds (IDLE only)
//   w_valid, w_i : message-schedule word stream; consumed when w_valid && w_ready
//   w_ready      : high in ROUND
//   busy         : high in ROUND and FINAL
//   round_o      : current round index t
//   digest       : {H0..H7}, H0 in [255:224]
//   digest_valid : high after FINAL until the next accepted chunk_start/msg_init
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         msg_init,
    input  logic         chunk_start,
    input  logic         w_valid,
    input  logic [31:0]  w_i,
    output logic         w_ready,
    output logic         busy,
    output logic [5:0]   round_o,
    output logic [255:0] digest,
    output logic         digest_valid
);

    state_e      r_state;
    logic [5:0]  r_t;
    logic [31:0] r_work [8];  // a..h, index 0 is a
    logic [31:0] r_hash [8];  // H0..H7
    logic        r_w_ready;
    logic        r_busy;
    logic        r_digest_valid;

    logic [31:0] w_k;
    logic [31:0] w_t1;
    logic [31:0] w_t2;

    sha256_k_rom u_k_rom (
        .i_addr (r_t),
        .o_data (w_k)
    );

    assign w_t1 = r_work[7] + big_sigma1(r_work[4]) + ch(r_work[4], r_work[5], r_work[6])
                + w_k + w_i;
    assign w_t2 = big_sigma0(r_work[0]) + maj(r_work[0], r_work[1], r_work[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_t            <= 6'd0;
            r_w_ready      <= 1'b0;
            r_busy         <= 1'b0;
            r_digest_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_work[i] <= 32'd0;
                r_hash[i] <= IV_W[i];
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (msg_init) begin
                        r_digest_valid <= 1'b0;
                        for (int i = 0; i < 8; i++) r_hash[i] <= IV_W[i];
                    end
                    if (chunk_start) begin
                        // Simultaneous msg_init bypasses H so the new message starts now.
                        for (int i = 0; i < 8; i++) begin
                            r_work[i] <= msg_init ? IV_W[i] : r_hash[i];
                        end
                        r_t            <= 6'd0;
                        r_digest_valid <= 1'b0;
                        r_w_ready      <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_valid) begin
                        r_work[0] <= w_t1 + w_t2;
                        r_work[1] <= r_work[0];
                        r_work[2] <= r_work[1];
                        r_work[3] <= r_work[2];
                        r_work[4] <= r_work[3] + w_t1;
                        r_work[5] <= r_work[4];
                        r_work[6] <= r_work[5];
                        r_work[7] <= r_work[6];
                        r_t       <= r_t + 6'd1;
                        if (r_t == 6'd63) begin
                            r_w_ready <= 1'b0;
                            r_state   <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) r_hash[i] <= r_hash[i] + r_work[i];
                    r_digest_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_ready      = r_w_ready;
    assign busy         = r_busy;
    assign round_o      = r_t;
    assign digest_valid = r_digest_valid;
    assign digest       = {r_hash[0], r_hash[1], r_hash[2], r_hash[3],
                           r_hash[4], r_hash[5], r_hash[6], r_hash[7]};

endmodule
